// File: rtl/mmio_board_io_pkg.sv
// Shared register offsets and seven-segment constants for the board I/O slave.
package mmio_board_io_pkg;

    localparam logic [2:0] REG_SEG_DATA = 3'd0;
    localparam logic [2:0] REG_SEG_CTRL = 3'd1;
    localparam logic [2:0] REG_LED      = 3'd2;
    localparam logic [2:0] REG_SW       = 3'd3;
    localparam logic [2:0] REG_BTN      = 3'd4;
    localparam logic [2:0] REG_BTN_EDGE = 3'd5;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-high {g..a} patterns, entry 15 first so HEX7_TABLE[n] selects digit n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/mmio_board_io_seg7_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern {g..a}.
module seg7_hex_decoder
    import mmio_board_io_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/mmio_board_io.sv
// Memory-mapped board I/O: seven-segment scan, LEDs, synchronised switches and
// debounced buttons with sticky press flags for CPU loads.
module mmio_board_io
    import mmio_board_io_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_DIV = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [7:0]  sw,
    input  logic [4:0]  btn,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [7:0]  led
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_DIV - 1);

    logic [15:0]       seg_data_q;
    logic [7:0]        seg_ctrl_q, led_q;
    logic [7:0]        sw_meta_q, sw_sync_q;
    logic [4:0]        btn_meta_q, btn_sync_q, btn_prev_q, btn_db_q, btn_edge_q;
    logic [4:0]        btn_db_d, btn_edge_d, btn_agree, edge_clr;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [1:0]        idx_q;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        hex_seg;
    logic [3:0]        nibble;
    logic              wr_en, rd_en, db_tick, scan_wrap, digit_en, digit_dp;
    logic [2:0]        reg_sel;
    logic              unused_bits;

    assign wr_en     = ce & we;
    assign rd_en     = ce & ~we;
    assign reg_sel   = addr[4:2];
    assign db_tick   = (db_cnt_q == DB_LAST);
    assign scan_wrap = (scan_cnt_q == SCAN_LAST);
    assign unused_bits = ^{addr[31:5], addr[1:0], data_i[31:16], sel[3:2]};

    // A bit is accepted only when two consecutive tick samples agree.
    assign btn_agree = ~(btn_sync_q ^ btn_prev_q);
    assign btn_db_d  = db_tick ? ((btn_agree & btn_sync_q) | (~btn_agree & btn_db_q)) : btn_db_q;
    assign edge_clr  = (wr_en && reg_sel == REG_BTN_EDGE && sel[0]) ? data_i[4:0] : 5'd0;
    assign btn_edge_d = (btn_edge_q & ~edge_clr) | (btn_db_d & ~btn_db_q);

    assign nibble   = seg_data_q[{idx_q, 2'b00} +: 4];
    assign digit_en = seg_ctrl_q[{1'b0, idx_q}];
    assign digit_dp = seg_ctrl_q[{1'b1, idx_q}];

    seg7_hex_decoder u_hex (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

    assign seg_d = digit_en ? ~{digit_dp, hex_seg} : SEG_BLANK;
    assign an_d  = digit_en ? ~(4'b0001 << idx_q) : 4'hF;

    always_comb begin
        data_o = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_SEG_DATA: data_o = {16'h0, seg_data_q};
                REG_SEG_CTRL: data_o = {24'h0, seg_ctrl_q};
                REG_LED:      data_o = {24'h0, led_q};
                REG_SW:       data_o = {24'h0, sw_sync_q};
                REG_BTN:      data_o = {27'h0, btn_db_q};
                REG_BTN_EDGE: data_o = {27'h0, btn_edge_q};
                default:      data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data_q <= '0;
            seg_ctrl_q <= '0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
            btn_db_q   <= '0;
            btn_edge_q <= '0;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;

            db_cnt_q <= db_tick ? '0 : db_cnt_q + DB_W'(1);
            if (db_tick) btn_prev_q <= btn_sync_q;
            btn_db_q   <= btn_db_d;
            btn_edge_q <= btn_edge_d;

            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
            if (scan_wrap) idx_q <= idx_q + 2'd1;
            seg_q <= seg_d;
            an_q  <= an_d;

            if (wr_en) begin
                case (reg_sel)
                    REG_SEG_DATA: begin
                        if (sel[0]) seg_data_q[7:0]  <= data_i[7:0];
                        if (sel[1]) seg_data_q[15:8] <= data_i[15:8];
                    end
                    REG_SEG_CTRL: if (sel[0]) seg_ctrl_q <= data_i[7:0];
                    REG_LED:      if (sel[0]) led_q      <= data_i[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign led = led_q;

endmodule

// File: tb/tb_mmio_board_io.sv
// Self-checking bench for mmio_board_io: directed test-plan sequences plus a
// randomized phase, all compared each cycle against a tick-arithmetic model.
module tb_mmio_board_io;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_DIV = 8;

    logic        clk = 1'b0, rst = 1'b0, ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, data_i = '0;
    logic [3:0]  sel = '0;
    logic [7:0]  sw = '0;
    logic [4:0]  btn = '0;
    logic [31:0] data_o;
    logic [7:0]  seg, led;
    logic [3:0]  an;

    mmio_board_io #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_DIV(DEBOUNCE_DIV)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .sw(sw), .btn(btn),
        .seg(seg), .an(an), .led(led)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Model: m_k counts clock edges since reset; digit slots and debounce ticks
    // follow directly from it. sh*/bh* hold raw pin values seen at the last two edges.
    int          m_k = 0, m_idx = 0;
    logic [15:0] m_data = '0;
    logic [7:0]  m_ctrl = '0, m_led = '0, m_seg = 8'hFF, sh0 = '0, sh1 = '0;
    logic [3:0]  m_an = 4'hF;
    logic [4:0]  bh0 = '0, bh1 = '0, m_last = '0, m_db = '0, m_edge = '0, m_nd, m_clr;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_k = 0; m_data = '0; m_ctrl = '0; m_led = '0; m_seg = 8'hFF; m_an = 4'hF;
            sh0 = '0; sh1 = '0; bh0 = '0; bh1 = '0; m_last = '0; m_db = '0; m_edge = '0;
        end else begin
            m_idx = (m_k / SCAN_DIV) % 4;
            if (m_ctrl[m_idx]) begin
                m_an  = ~(4'b0001 << m_idx);
                m_seg = ~{m_ctrl[4 + m_idx], hex7(m_data[4 * m_idx +: 4])};
            end else begin
                m_an  = 4'hF;
                m_seg = 8'hFF;
            end
            m_k++;
            m_nd = m_db;
            if (m_k % DEBOUNCE_DIV == 0) begin
                for (int i = 0; i < 5; i++) if (bh1[i] == m_last[i]) m_nd[i] = bh1[i];
                m_last = bh1;
            end
            m_clr  = (ce && we && addr[4:2] == 3'd5 && sel[0]) ? data_i[4:0] : 5'd0;
            m_edge = (m_edge & ~m_clr) | (m_nd & ~m_db);
            m_db   = m_nd;
            if (ce && we) begin
                case (addr[4:2])
                    3'd0: begin
                        if (sel[0]) m_data[7:0]  = data_i[7:0];
                        if (sel[1]) m_data[15:8] = data_i[15:8];
                    end
                    3'd1: if (sel[0]) m_ctrl = data_i[7:0];
                    3'd2: if (sel[0]) m_led  = data_i[7:0];
                    default: ;
                endcase
            end
            sh1 = sh0; sh0 = sw; bh1 = bh0; bh0 = btn;
        end
    end

    function automatic logic [31:0] m_read();
        if (!(ce && !we)) return 32'h0;
        case (addr[4:2])
            3'd0: return {16'h0, m_data};
            3'd1: return {24'h0, m_ctrl};
            3'd2: return {24'h0, m_led};
            3'd3: return {24'h0, sh1};
            3'd4: return {27'h0, m_db};
            3'd5: return {27'h0, m_edge};
            default: return 32'h0;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        chk("seg", 32'(seg), 32'(m_seg));
        chk("an", 32'(an), 32'(m_an));
        chk("led", 32'(led), 32'(m_led));
        chk("data_o", data_o, m_read());
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "bench timeout");
    end

    task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b1; addr = {27'h0, r, 2'b00}; data_i = d; sel = s;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] r, output logic [31:0] d);
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = {27'h0, r, 2'b00}; sel = 4'h0;
        @(negedge clk); #1;
        d = data_o;
        ce = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (an == v) ok = 1'b1;
        end
    endtask

    task automatic wait_btn(input logic [4:0] v, output logic ok, output int n);
        logic [31:0] d;
        ok = 1'b0; n = 0;
        while (!ok && n < 30) begin
            bus_read(3'd4, d);
            n++;
            if (d == {27'h0, v}) ok = 1'b1;
        end
    endtask

    logic [31:0] d;
    logic        ok;
    int          n, bad, k0, t;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_seg", 32'(seg), 32'hFF);
        chk("reset_an", 32'(an), 32'hF);
        for (int r = 0; r < 8; r++) begin
            bus_read(3'(r), d);
            chk($sformatf("reset_read%0d", r), d, 32'h0);
        end

        bus_write(3'd0, 32'h0000_12AF, 4'hF);
        bus_write(3'd1, 32'h0000_002F, 4'h1);
        wait_an(4'hE, ok); chk("an_E_seen", 32'(ok), 32'h1); chk("seg_digit0", 32'(seg), 32'h8E);
        wait_an(4'hD, ok); chk("an_D_seen", 32'(ok), 32'h1); chk("seg_digit1_dp", 32'(seg), 32'h08);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (an != 4'hD) break;
            n++;
        end
        chk("scan_dwell", 32'(n), 32'd4);
        chk("an_B_next", 32'(an), 32'hB); chk("seg_digit2", 32'(seg), 32'hA4);
        wait_an(4'h7, ok); chk("an_7_seen", 32'(ok), 32'h1); chk("seg_digit3", 32'(seg), 32'hF9);

        bus_write(3'd1, 32'h0000_0005, 4'h1);
        repeat (2) @(negedge clk);
        n = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (an == 4'hF) n++;
            if (seg == 8'hFF) bad++;
        end
        chk("disabled_an_cycles", 32'(n), 32'd8);
        chk("disabled_seg_cycles", 32'(bad), 32'd8);

        bus_write(3'd2, 32'hFFFF_FFFF, 4'b0001); chk("led_lane0", 32'(led), 32'hFF);
        bus_write(3'd2, 32'h0000_0000, 4'b1110); chk("led_upper_lanes", 32'(led), 32'hFF);
        bus_read(3'd2, d); chk("led_read", d, 32'h0000_00FF);

        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = 32'h8; rst = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'hFF); chk("rst_an", 32'(an), 32'hF);
        chk("rst_led", 32'(led), 32'h0); chk("rst_data_o", data_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0; ce = 1'b0;
        bus_read(3'd0, d); chk("rst_seg_data", d, 32'h0);
        bus_read(3'd1, d); chk("rst_seg_ctrl", d, 32'h0);
        bus_read(3'd2, d); chk("rst_led_reg", d, 32'h0);

        @(posedge clk); #1;
        sw = 8'hA5; ce = 1'b1; we = 1'b0; addr = 32'hC;
        @(posedge clk); #1 chk("sw_lag1", data_o, 32'h0);
        @(posedge clk); #1 chk("sw_lag2", data_o, 32'hA5);
        ce = 1'b0;

        // Toggles every 8 cycles: every pair of consecutive samples straddles a toggle.
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 8 == 0 && c < 32) btn[2] = ~btn[2];
            bus_read(3'd4, d);
            if (d != 32'h0) bad++;
        end
        chk("bounce_btn_nonzero", 32'(bad), 32'd0);
        bus_read(3'd5, d); chk("bounce_edge", d, 32'h0);

        btn[2] = 1'b1;
        wait_btn(5'h04, ok, n);
        chk("btn_accept", 32'(ok), 32'h1);
        chk("btn_accept_in_18", 32'(n <= 18), 32'h1);
        bus_read(3'd5, d); chk("edge_set", d, 32'h4);
        bus_write(3'd5, 32'h4, 4'h1);
        bus_read(3'd5, d); chk("edge_w1c", d, 32'h0);

        btn[2] = 1'b0;
        wait_btn(5'h00, ok, n); chk("btn_release", 32'(ok), 32'h1);
        btn[2] = 1'b1;
        wait_btn(5'h04, ok, n); chk("btn_repress", 32'(ok), 32'h1);
        bus_read(3'd5, d); chk("edge_reset_again", d, 32'h4);

        btn[2] = 1'b0;
        wait_btn(5'h00, ok, n); chk("btn_release2", 32'(ok), 32'h1);
        bus_write(3'd5, 32'h4, 4'h1);
        bus_read(3'd5, d); chk("edge_clear2", d, 32'h0);
        @(posedge clk); #1;
        btn[2] = 1'b1;
        k0 = m_k;
        // First tick that samples the press, then the accepting tick one period later.
        t = ((k0 + 3 + DEBOUNCE_DIV - 1) / DEBOUNCE_DIV) * DEBOUNCE_DIV + DEBOUNCE_DIV;
        n = 0;
        while (m_k < t - 1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ce = 1'b1; we = 1'b1; addr = 32'h14; data_i = 32'h4; sel = 4'h1;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
        bus_read(3'd4, d); chk("collide_btn", d, 32'h4);
        bus_read(3'd5, d); chk("collide_edge_set_wins", d, 32'h4);

        for (int it = 0; it < 1500; it++) begin
            @(posedge clk); #1;
            ce = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            addr = $urandom;
            data_i = $urandom;
            sel = 4'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 23) == 0) btn[i] = ~btn[i];
            if (it == 700) rst = 1'b1;
            if (it == 702) rst = 1'b0;
        end
        ce = 1'b0; we = 1'b0;
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
